// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Load bus feeding the seven-segment scan driver.
//   iLOAD  : single-cycle strobe capturing iDIG/iDP/iBLANK
//   iDIG   : packed hex values, bits [3:0] = digit 0 (rightmost)
//   iDP    : decimal point request per digit, 1 = lit
//   iBLANK : force digit dark, 1 = blank
//   master : producer of display values; slave : seg7_scan_driver
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                    iLOAD;
   logic [4*NUM_DIGITS-1:0] iDIG;
   logic [NUM_DIGITS-1:0]   iDP;
   logic [NUM_DIGITS-1:0]   iBLANK;

   modport master (output iLOAD, iDIG, iDP, iBLANK);
   modport slave  (input  iLOAD, iDIG, iDP, iBLANK);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on a
//   shared segment bus. Each digit slot is SCAN_DIV cycles: BLANK_CYCLES of
//   dead time (all digits off) followed by the lit portion. Loaded values sit
//   in shadow registers and reach the display registers only at a frame
//   boundary, so a digit never changes mid-frame.
//   Optional macro SEG7_LZB_EN enables leading-zero blanking.
// Ports:
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   iEN          : scan enable, low = all digits dark
//   bus          : load bus (iLOAD, iDIG, iDP, iBLANK), slave side
//   oSEG         : segments a..g (bit0=a), active-low
//   oSEG_DP      : decimal point, active-low
//   oDIG_EN      : digit enables, polarity per DIG_ACTIVE_LOW
//   oFRAME       : one-cycle pulse at the start of each frame
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iEN,
   seg7_scan_driver_if.slave     bus,
   output logic [6:0]            oSEG,
   output logic                  oSEG_DP,
   output logic [NUM_DIGITS-1:0] oDIG_EN,
   output logic                  oFRAME
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    frame_start;

   logic [4*NUM_DIGITS-1:0] sh_dig_q, disp_dig_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q, disp_dp_q;
   logic [NUM_DIGITS-1:0]   sh_blank_q, disp_blank_q;
   logic [NUM_DIGITS-1:0]   hide;

   logic [3:0]              cur_val;
   logic [NUM_DIGITS-1:0]   en_vec;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   den_q, den_d;
   logic                    frame_q, frame_d;

   // Active-low glyphs, g..a
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0011000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Scan state: one slot counter spans BLANK and SHOW of a digit slot.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      frame_start = 1'b0;
      if (!iEN) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Leaving IDLE starts a fresh frame, so it is a frame boundary too.
               state_d     = S_BLANK;
               cnt_d       = '0;
               idx_d       = '0;
               frame_start = 1'b1;
            end
            S_BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = S_SHOW;
            end
            S_SHOW: begin
               if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                     idx_d       = '0;
                     frame_start = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Double buffering; a load coinciding with a boundary bypasses the shadow.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sh_dig_q     <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         disp_dig_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '0;
      end else begin
         if (bus.iLOAD) begin
            sh_dig_q   <= bus.iDIG;
            sh_dp_q    <= bus.iDP;
            sh_blank_q <= bus.iBLANK;
         end
         if (frame_start) begin
            if (bus.iLOAD) begin
               disp_dig_q   <= bus.iDIG;
               disp_dp_q    <= bus.iDP;
               disp_blank_q <= bus.iBLANK;
            end else begin
               disp_dig_q   <= sh_dig_q;
               disp_dp_q    <= sh_dp_q;
               disp_blank_q <= sh_blank_q;
            end
         end
      end
   end

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0] lzb_mask;
   logic                  lz_run;

   // Walk from the most significant digit down to digit 1; stop at the first
   // nonzero value or lit decimal point. Digit 0 is never considered.
   always_comb begin
      lzb_mask = '0;
      lz_run   = 1'b1;
      for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
         if (lz_run && (disp_dig_q[4*(NUM_DIGITS-k) +: 4] == 4'h0)
             && !disp_dp_q[NUM_DIGITS-k])
            lzb_mask[NUM_DIGITS-k] = 1'b1;
         else
            lz_run = 1'b0;
      end
   end

   assign hide = disp_blank_q | lzb_mask;
`else
   assign hide = disp_blank_q;
`endif

   // Output decode; iEN low darkens outputs on the very next edge.
   always_comb begin
      seg_d   = '1;
      dp_d    = 1'b1;
      en_vec  = '0;
      frame_d = 1'b0;
      cur_val = disp_dig_q[{idx_q, 2'b00} +: 4];
      if (iEN) begin
         frame_d = (state_q == S_BLANK) && (idx_q == '0) && (cnt_q == '0);
         if ((state_q == S_SHOW) && !hide[idx_q]) begin
            seg_d         = glyph(cur_val);
            dp_d          = ~disp_dp_q[idx_q];
            en_vec[idx_q] = 1'b1;
         end
      end
      den_d = DIG_ACTIVE_LOW ? ~en_vec : en_vec;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         seg_q   <= '1;
         dp_q    <= 1'b1;
         den_q   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         den_q   <= den_d;
         frame_q <= frame_d;
      end
   end

   assign oSEG    = seg_q;
   assign oSEG_DP = dp_q;
   assign oDIG_EN = den_q;
   assign oFRAME  = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots,
//   2 dead-time cycles, active-low enables). The reference model tracks the
//   scan position as "edges since scanning started" and derives digit/phase
//   with division; displayed values change only at multiples of the frame
//   length. Define SEG7_LZB_EN for both RTL and bench to cover leading-zero
//   blanking.
module tb_seg7_scan_driver;
   localparam int N  = 4;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FL = N * SD;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         en    = 1'b0;
   logic [6:0]   seg;
   logic         sdp;
   logic [N-1:0] den;
   logic         frm;

   seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS    (N),
      .SCAN_DIV      (SD),
      .BLANK_CYCLES  (BC),
      .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .iEN    (en),
      .bus    (bus),
      .oSEG   (seg),
      .oSEG_DP(sdp),
      .oDIG_EN(den),
      .oFRAME (frm)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [6:0] glyph_ref [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference model state
   bit          active_m;
   int          t_m;
   logic [15:0] sh_dig_m, dsp_dig_m;
   logic [3:0]  sh_dp_m, dsp_dp_m, sh_bl_m, dsp_bl_m;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_en;
   logic        e_fr;

   task automatic reset_model();
      active_m  = 1'b0;
      t_m       = 0;
      sh_dig_m  = '0; dsp_dig_m = '0;
      sh_dp_m   = '0; dsp_dp_m  = '0;
      sh_bl_m   = '0; dsp_bl_m  = '0;
   endtask

   function automatic bit hidden_m(int d);
      bit h;
      h = dsp_bl_m[d];
`ifdef SEG7_LZB_EN
      if (d > 0) begin
         bit all0;
         all0 = 1'b1;
         for (int k = d; k < N; k++)
            if (dsp_dig_m[4*k +: 4] != 4'h0 || dsp_dp_m[k]) all0 = 1'b0;
         if (all0) h = 1'b1;
      end
`endif
      return h;
   endfunction

   // Predict outputs for the coming edge from the pre-edge scan position, then
   // advance the model with the inputs sampled on that edge, then clock.
   task automatic tick();
      int p, d, ph;
      bit bnd;
      e_seg = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fr = 1'b0;
      if (en && active_m) begin
         p    = t_m % FL;
         d    = p / SD;
         ph   = p % SD;
         e_fr = (p == 0);
         if (ph >= BC && !hidden_m(d)) begin
            e_seg = glyph_ref[dsp_dig_m[4*d +: 4]];
            e_dp  = ~dsp_dp_m[d];
            e_en  = ~(4'b0001 << d);
         end
      end
      bnd = 1'b0;
      if (!en) begin
         active_m = 1'b0;
         t_m      = 0;
      end else if (!active_m) begin
         active_m = 1'b1;
         t_m      = 0;
         bnd      = 1'b1;
      end else begin
         t_m++;
         bnd = (t_m % FL == 0);
      end
      if (bus.iLOAD) {sh_dig_m, sh_dp_m, sh_bl_m} = {bus.iDIG, bus.iDP, bus.iBLANK};
      if (bnd) {dsp_dig_m, dsp_dp_m, dsp_bl_m} = {sh_dig_m, sh_dp_m, sh_bl_m};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0;
      bus.iLOAD = 1'b0; bus.iDIG = '0; bus.iDP = '0; bus.iBLANK = '0;
      #23;
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, 7'h7F); end
      checks++; if (sdp !== 1'b1)  begin errors++; $display("FAIL reset_dp: got %b expected 1", sdp); end
      checks++; if (den !== 4'hF)  begin errors++; $display("FAIL reset_en: got %b expected 1111", den); end
      checks++; if (frm !== 1'b0)  begin errors++; $display("FAIL reset_frame: got %b expected 0", frm); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      reset_model();
      repeat (3) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL idle cyc%0d: got seg/dp/en/fr=%b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
   endtask

   task automatic test_basic();
      int last_fr;
      last_fr = -1;
      bus.iDIG = 16'h12AF; bus.iDP = 4'b0001; bus.iBLANK = 4'b0000; bus.iLOAD = 1'b1;
      tick();
      bus.iLOAD = 1'b0;
      en = 1'b1;
      repeat (80) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL basic cyc%0d: got seg/dp/en/fr=%b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
         if (frm) begin
            if (last_fr >= 0) begin
               checks++;
               if (cyc - last_fr !== FL) begin errors++; $display("FAIL frame_period: got %0d expected %0d", cyc - last_fr, FL); end
            end
            last_fr = cyc;
         end
         if (den == 4'b1110) begin
            checks++;
            if ({seg, sdp} !== {7'b0001110, 1'b0}) begin errors++; $display("FAIL digit0_F: got %b expected %b", {seg, sdp}, {7'b0001110, 1'b0}); end
         end
         if (den == 4'b0111) begin
            checks++;
            if ({seg, sdp} !== {7'b1111001, 1'b1}) begin errors++; $display("FAIL digit3_1: got %b expected %b", {seg, sdp}, {7'b1111001, 1'b1}); end
         end
      end
      checks++;
      if (last_fr < 0) begin errors++; $display("FAIL frame_seen: got none expected a pulse"); end
   endtask

   task automatic test_midframe_load();
      int g;
      g = 0;
      do begin
         tick(); g++;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL mid_wait cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end while (!(active_m && t_m % FL == 11) && g < 2*FL);
      bus.iDIG = 16'h3333; bus.iDP = '0; bus.iBLANK = '0; bus.iLOAD = 1'b1;
      g = 0;
      do begin
         tick(); g++;
         bus.iLOAD = 1'b0;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL mid_old cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end while (!(t_m % FL == 1) && g < 2*FL);
      repeat (FL) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL mid_new cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
         if (den != 4'hF) begin
            checks++;
            if (seg !== 7'b0110000) begin errors++; $display("FAIL mid_three: got %b expected 0110000", seg); end
         end
      end
      // Present a load on the cycle whose edge is the frame boundary.
      g = 0;
      while (t_m % FL != FL - 1 && g < 2*FL) begin
         tick(); g++;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL bnd_wait cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
      bus.iDIG = 16'h4567; bus.iLOAD = 1'b1;
      repeat (FL) begin
         tick();
         bus.iLOAD = 1'b0;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL bnd_load cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
         if (den == 4'b1110) begin
            checks++;
            if (seg !== 7'b1111000) begin errors++; $display("FAIL bnd_digit0: got %b expected 1111000", seg); end
         end
      end
   endtask

   task automatic test_blank();
      int g, first3;
      bus.iDIG = {4'h9, 12'($urandom)}; bus.iDP = 4'($urandom); bus.iBLANK = 4'b0100; bus.iLOAD = 1'b1;
      g = 0;
      do begin
         tick(); g++;
         bus.iLOAD = 1'b0;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL blank_wait cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end while (!(t_m % FL == 1) && g < 3*FL);
      checks++;
      if (frm !== 1'b1) begin errors++; $display("FAIL blank_frame: got %b expected 1", frm); end
      first3 = -1;
      for (int k = 1; k <= FL + 8; k++) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL blank cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
         checks++;
         if (den[2] !== 1'b1) begin errors++; $display("FAIL blank_en2: got %b expected 1", den[2]); end
         if (den == 4'b0111 && first3 < 0) first3 = k;
      end
      checks++;
      if (first3 != 26) begin errors++; $display("FAIL blank_d3_offset: got %0d expected 26", first3); end
   endtask

   task automatic test_enable();
      int g;
      g = 0;
      while (!(active_m && (t_m % FL) / SD == 1 && t_m % SD == 4) && g < 2*FL) begin
         tick(); g++;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL en_wait cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
      checks++;
      if (den !== 4'b1101) begin errors++; $display("FAIL en_pre: got %b expected 1101", den); end
      en = 1'b0;
      tick();
      checks++;
      if ({seg, sdp, den} !== {7'h7F, 1'b1, 4'hF}) begin errors++; $display("FAIL en_drop: got %b expected %b", {seg, sdp, den}, {7'h7F, 1'b1, 4'hF}); end
      repeat (3) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL en_idle cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
      en = 1'b1;
      // Edge 1 samples iEN (IDLE exit), edges 2-3 are dead time, edge 4 shows digit 0.
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (k < 4 && den !== 4'hF) begin errors++; $display("FAIL en_restart_dark k%0d: got %b expected 1111", k, den); end
         if (k == 4 && den !== 4'b1110) begin errors++; $display("FAIL en_restart_lit: got %b expected 1110", den); end
      end
   endtask

   task automatic test_async_reset();
      int g;
      g = 0;
      while (!(active_m && t_m % SD == 5 && (t_m % FL) / SD != 2) && g < 2*FL) begin
         tick(); g++;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL ar_wait cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
      checks++;
      if (den === 4'hF) begin errors++; $display("FAIL ar_pre: got %b expected one digit lit", den); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, sdp, den, frm} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
         errors++; $display("FAIL ar_dark: got %b expected %b", {seg, sdp, den, frm}, {7'h7F, 1'b1, 4'hF, 1'b0});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      reset_model();
      repeat (FL + 4) begin
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL ar_after cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
   endtask

`ifdef SEG7_LZB_EN
   task automatic test_lzb();
      bus.iDIG = 16'h0050; bus.iDP = '0; bus.iBLANK = '0; bus.iLOAD = 1'b1;
      repeat (3*FL) begin
         tick();
         bus.iLOAD = 1'b0;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL lzb cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
         if (t_m > FL + 1) begin
            checks++;
            if (den[3] !== 1'b1 || den[2] !== 1'b1) begin errors++; $display("FAIL lzb_lead: got %b expected 11xx", den); end
         end
      end
      bus.iDIG = 16'h0000; bus.iLOAD = 1'b1;
      repeat (3*FL) begin
         tick();
         bus.iLOAD = 1'b0;
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL lzb0 cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
   endtask
`endif

   task automatic test_random();
      repeat (600) begin
         if ($urandom_range(0, 9) == 0) begin
            bus.iDIG   = 16'($urandom);
            bus.iDP    = 4'($urandom);
            bus.iBLANK = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus.iLOAD  = 1'b1;
         end else begin
            bus.iLOAD = 1'b0;
         end
         if (en && $urandom_range(0, 79) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
         tick();
         checks++;
         if ({seg, sdp, den, frm} !== {e_seg, e_dp, e_en, e_fr}) begin
            errors++; $display("FAIL random cyc%0d: got %b expected %b", cyc, {seg, sdp, den, frm}, {e_seg, e_dp, e_en, e_fr});
         end
      end
      bus.iLOAD = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_midframe_load();
      test_blank();
      test_enable();
      test_async_reset();
`ifdef SEG7_LZB_EN
      test_lzb();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
